ram2_arbiter: RTL
=================

Name: ram2_arbiter

Overview:
- Shares the single RAM2 SRAM port between two requesters: IF-stage instruction fetch (read-only) and EXE-stage data access (read/write).
- Sequences each access through a fixed setup/access/complete state machine and drives the SRAM control strobes.
- Returns a one-cycle done pulse and read data to the winning requester.
- Sits between the IF/EXE memory controllers and the RAM2 pins; the stall controller consumes `busy` and the done pulses.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 1, ACCESS-state cycles for a read (legal range 1..15).
- WR_WAIT, 2, ACCESS-state cycles with WE low for a write (legal range 1..15).

Ports:
- clk  in  1  system clock; every flop updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  16  fetch address; zero-extended to ADDR_W.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_data  out  DATA_W  fetched word; valid with if_done; held until the next fetch capture.
- exe_req  in  1  data request; level, held until exe_done.
- exe_wr  in  1  1 = write, 0 = read; sampled only at grant.
- exe_addr  in  ADDR_W  data address.
- exe_wdata  in  DATA_W  write data; sampled at grant.
- exe_done  out  1  one-cycle pulse: data access complete.
- exe_rdata  out  DATA_W  read word; valid with exe_done; held until the next EXE read capture.
- busy  out  1  high in every non-IDLE state.
- ram2_addr  out  ADDR_W  SRAM address.
- ram2_data  inout  DATA_W  SRAM data bus.
- ram2_en  out  1  chip enable, active low.
- ram2_oe  out  1  output enable, active low.
- ram2_rw  out  1  write enable, active low.

Behaviour:
- Reset:
  - State = IDLE.
  - ram2_en = ram2_oe = ram2_rw = 1.
  - ram2_addr = 0; ram2_data = Z.
  - if_done = exe_done = 0; if_data = exe_rdata = 0; busy = 0.
  - Internal grant/last-grant registers cleared.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - No request pending: stay in IDLE, all strobes high.
  - A request pending: latch requester id, address, write flag and write data, then go to SETUP.
- SETUP (1 cycle):
  - ram2_addr driven and ram2_en = 0.
  - Read: ram2_oe = 0.
  - Write: ram2_data driven, ram2_oe = 1, ram2_rw = 1.
  - Wait counter loaded with RD_WAIT or WR_WAIT.
- ACCESS (RD_WAIT or WR_WAIT cycles):
  - Read: oe stays 0; ram2_data is sampled into the requester's data register on the last ACCESS cycle.
  - Write: ram2_rw = 0 throughout.
- DONE (1 cycle):
  - ram2_rw = 1; for a write, address and data remain driven as hold time.
  - oe returns to 1; the granted requester's done = 1.
  - Next state is IDLE unconditionally.
- Latency: request sampled in IDLE at edge T gives done high in cycle T+2+N, where N is the wait count.
  - Default read completes at T+3; default write at T+4.
- Arbitration: fixed priority, EXE over IF, decided only in IDLE. No preemption once granted.
- ram2_data is driven only during write SETUP/ACCESS/DONE; otherwise Z.
- Request dropped mid-transaction: the access still completes and done still pulses. A write is never truncated.
- Requester still asserting req in the cycle after done: treated as a new request and re-arbitrated in IDLE.
- Both requests arriving while busy: both wait; arbitration occurs in the next IDLE.
- rst asserted mid-access: takes effect at the next edge.
  - WE is deasserted immediately, the bus is released, and no done pulse is issued.
  - Data registers clear to 0.
- if_addr is zero-extended; exe_addr is used as is. Addresses do not wrap or increment.

Optional Feature:
- Macro: RAM2_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requests are pending in IDLE, grant goes to the requester not granted last; last-grant resets to IF, so EXE wins the first tie.
  - A single pending requester is always granted.
- Undefined: fixed EXE-over-IF priority; the last-grant register is not built.

Test Plan:
- IF read only: if_addr=16'h0012, SRAM word 16'hA5C3 -> en/oe low from T+1, if_done pulse at T+3, if_data=16'hA5C3; ram2_data stays Z throughout.
- EXE write: exe_addr=18'h00100, exe_wdata=16'h1234 -> ram2_rw low exactly 2 cycles, data driven for 4 cycles, exe_done at T+4; a later read of 18'h00100 returns 16'h1234.
- Simultaneous if_req and exe_req (macro off) -> EXE served first, then IF. The first done is exe_done and the second is if_done; busy is low for exactly one cycle between the two accesses.
- Same scenario with RAM2_ARB_RR_EN and both requests held continuously -> grants alternate EXE, IF, EXE, IF.
- rst asserted during ACCESS of a write -> next cycle ram2_rw=1, en=1, ram2_data=Z, no exe_done, state IDLE.
- exe_req dropped during SETUP of a read -> exe_done still pulses at T+3 and the arbiter returns to IDLE with no second access.

Source files
------------

// File: rtl/ram2_arbiter.sv
// RAM2 SRAM port arbiter.
// Shares one asynchronous SRAM port between the IF-stage fetch path (read-only)
// and the EXE-stage data path (read/write). Each access runs through a fixed
// IDLE -> SETUP -> ACCESS -> DONE sequence that drives the active-low strobes.
//
// Optional feature: define RAM2_ARB_RR_EN for round-robin arbitration on ties.
// Without it, EXE always wins over IF.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_req/if_addr     fetch request (level) and 16-bit address, zero-extended
//   if_done/if_data    one-cycle completion pulse and fetched word
//   exe_req/exe_wr     data request (level) and write flag (sampled at grant)
//   exe_addr/exe_wdata data address and write data (sampled at grant)
//   exe_done/exe_rdata one-cycle completion pulse and read word
//   busy               high whenever the arbiter is not idle
//   ram2_*             SRAM address, data bus and active-low en/oe/rw strobes
module ram2_arbiter #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              exe_req,
  input  logic              exe_wr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic              exe_done,
  output logic [DATA_W-1:0] exe_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram2_addr,
  inout  wire  [DATA_W-1:0] ram2_data,
  output logic              ram2_en,
  output logic              ram2_oe,
  output logic              ram2_rw
);

  localparam logic [3:0] RdCnt = 4'(RD_WAIT);
  localparam logic [3:0] WrCnt = 4'(WR_WAIT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                gnt_exe_q, gnt_exe_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   exe_rdata_q, exe_rdata_d;
  logic                pick_exe;

`ifdef RAM2_ARB_RR_EN
  // Set when EXE held the most recent grant; cleared (IF) by reset so EXE wins
  // the first tie.
  logic last_exe_q, last_exe_d;

  assign pick_exe = exe_req & (~if_req | ~last_exe_q);

  always_comb begin
    last_exe_d = last_exe_q;
    if (state_q == StIdle && (exe_req || if_req)) begin
      last_exe_d = pick_exe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_exe_q <= 1'b0;
    end else begin
      last_exe_q <= last_exe_d;
    end
  end
`else
  assign pick_exe = exe_req;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_exe_d   = gnt_exe_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_data_d   = if_data_q;
    exe_rdata_d = exe_rdata_q;
    case (state_q)
      StIdle: begin
        if (exe_req || if_req) begin
          gnt_exe_d = pick_exe;
          wr_d      = pick_exe & exe_wr;
          addr_d    = pick_exe ? exe_addr : ADDR_W'(if_addr);
          wdata_d   = exe_wdata;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = wr_q ? WrCnt : RdCnt;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q <= 4'd1) begin
          state_d = StDone;
          // Read data is captured on the last ACCESS cycle so it is valid with done.
          if (!wr_q) begin
            if (gnt_exe_q) begin
              exe_rdata_d = ram2_data;
            end else begin
              if_data_d = ram2_data;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_exe_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_data_q   <= '0;
      exe_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_exe_q   <= gnt_exe_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_data_q   <= if_data_d;
      exe_rdata_q <= exe_rdata_d;
    end
  end

  // Strobes decode straight from the state register, so a reset releases the
  // bus and deasserts WE in the very next cycle.
  assign busy      = (state_q != StIdle);
  assign ram2_en   = ~busy;
  assign ram2_oe   = ~(~wr_q & (state_q == StSetup || state_q == StAccess));
  assign ram2_rw   = ~(wr_q & (state_q == StAccess));
  assign ram2_addr = busy ? addr_q : '0;
  // Write data stays on the bus through DONE as hold time.
  assign ram2_data = (busy && wr_q) ? wdata_q : {DATA_W{1'bz}};
  assign if_done   = (state_q == StDone) & ~gnt_exe_q;
  assign exe_done  = (state_q == StDone) & gnt_exe_q;
  assign if_data   = if_data_q;
  assign exe_rdata = exe_rdata_q;

endmodule
